// File: rtl/stepper_ctrl.sv
// Memory-mapped stepper-motor sequencer: firmware programs CTRL/PERIOD/COUNT,
// the block steps the coil phase table autonomously and reports via STATUS.
module stepper_ctrl #(
    parameter logic [11:0] BASE_ADDR = 12'hFF0,
    parameter int          PW        = 24,
    parameter int          CW        = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [11:0] address,
    input  logic [31:0] data,
    output logic [31:0] q,
    output logic [5:0]  ja
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          en_q, en_d;
    logic          dir_q, dir_d;
    logic          half_q, half_d;
    logic [PW-1:0] period_q, period_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [2:0]    idx_q, idx_d;
    logic          done_q, done_d;

    // Bus: a write commits on the clock edge where wren is high; reads are
    // purely combinational on address and have no side effects.
    logic [11:0] offset;
    logic        hit;
    logic        wr_ctrl, wr_period, wr_count, wr_status;
    logic        abort_req, start_req;
    logic [PW-1:0] reload;
    logic [2:0]  step_amt;
    logic        busy;
    logic [3:0]  coils;
    logic        unused_data;

    assign offset    = address - BASE_ADDR;
    assign hit       = (offset < 12'd4);
    assign wr_ctrl   = wren && hit && (offset[1:0] == 2'd0);
    assign wr_period = wren && hit && (offset[1:0] == 2'd1);
    assign wr_count  = wren && hit && (offset[1:0] == 2'd2);
    assign wr_status = wren && hit && (offset[1:0] == 2'd3);

    assign abort_req   = wr_ctrl && (data[3] || !data[0]);
    assign start_req   = wr_count && en_q && (data[CW-1:0] != '0);
    assign reload      = (period_q == '0) ? '0 : period_q - PW'(1);
    assign step_amt    = half_q ? 3'd1 : 3'd2;
    assign busy        = (state_q != S_IDLE);
    assign unused_data = ^data[31:PW];

    function automatic logic [3:0] phase_of(input logic [2:0] i);
        case (i)
            3'd0:    phase_of = 4'b0001;
            3'd1:    phase_of = 4'b0011;
            3'd2:    phase_of = 4'b0010;
            3'd3:    phase_of = 4'b0110;
            3'd4:    phase_of = 4'b0100;
            3'd5:    phase_of = 4'b1100;
            3'd6:    phase_of = 4'b1000;
            default: phase_of = 4'b1001;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            dir_q    <= 1'b0;
            half_q   <= 1'b0;
            period_q <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            idx_q    <= 3'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            dir_q    <= dir_d;
            half_q   <= half_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        dir_d    = dir_q;
        half_d   = half_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        done_d   = done_q;

        if (wr_ctrl) begin
            en_d   = data[0];
            dir_d  = data[1];
            half_d = data[2];
        end
        if (wr_period) period_d = data[PW-1:0];
        if (wr_status && data[1]) done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d = S_RUN;
                    rem_d   = data[CW-1:0];
                    cnt_d   = reload;
                    done_d  = 1'b0;
                end
            end
            S_RUN: begin
                // Abort has priority over a step falling due in the same cycle.
                if (abort_req) begin
                    state_d = S_IDLE;
                    rem_d   = '0;
                end else if (cnt_q == '0 && rem_q != '0) begin
                    idx_d = dir_q ? idx_q + step_amt : idx_q - step_amt;
                    rem_d = rem_q - CW'(1);
                    cnt_d = reload;
                    if (rem_q == CW'(1)) state_d = S_DONE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - PW'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Coils stay energised while idle to provide holding torque.
    assign coils = en_q ? phase_of(idx_q) : 4'b0000;
    assign ja    = {done_q, busy, coils};

    always_comb begin
        q = '0;
        if (hit) begin
            case (offset[1:0])
                2'd0: q[2:0]    = {half_q, dir_q, en_q};
                2'd1: q[PW-1:0] = period_q;
                2'd2: q[CW-1:0] = rem_q;
                default: begin
                    q[0]   = busy;
                    q[1]   = done_q;
                    q[6:4] = idx_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_ctrl.sv
// Directed bench for stepper_ctrl: expected coil changes (value + cycle) and
// register/ja read values are queued; one monitor pops and compares them.
module tb_stepper_ctrl;

    localparam logic [11:0] BASE = 12'hFF0;
    localparam logic [11:0] A_CTRL = BASE;
    localparam logic [11:0] A_PER  = BASE + 12'd1;
    localparam logic [11:0] A_CNT  = BASE + 12'd2;
    localparam logic [11:0] A_STAT = BASE + 12'd3;
    localparam logic        K_Q  = 1'b0;
    localparam logic        K_JA = 1'b1;

    logic        clock = 1'b0;
    logic        reset;
    logic        wren;
    logic [11:0] address;
    logic [31:0] data;
    logic [31:0] q;
    logic [5:0]  ja;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int s;

    logic [35:0] coil_q[$];
    logic [32:0] exp_q[$];
    string       nm_q[$];
    logic        chk_req = 1'b0;
    logic        mon_en  = 1'b0;
    logic [3:0]  prev_coil = 4'b0000;

    stepper_ctrl dut (
        .clock   (clock),
        .reset   (reset),
        .wren    (wren),
        .address (address),
        .data    (data),
        .q       (q),
        .ja      (ja)
    );

    // clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        wren    = 1'b1;
        address = a;
        data    = d;
        tick();
        wren = 1'b0;
        data = '0;
    endtask

    task automatic chk(input logic kind, input logic [11:0] a, input logic [31:0] e,
                       input string nm);
        address = a;
        exp_q.push_back({kind, e});
        nm_q.push_back(nm);
        chk_req = 1'b1;
        tick();
        chk_req = 1'b0;
    endtask

    task automatic expect_coil(input logic [3:0] c, input int at);
        coil_q.push_back({at[31:0], c});
    endtask

    // scoreboard monitor
    initial begin
        logic [32:0] e;
        logic [31:0] act;
        logic [35:0] ce;
        logic [3:0]  cur;
        string       nm;
        forever begin
            @(negedge clock);
            if (chk_req) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL read_queue: read strobe with no expected value");
                end else begin
                    e  = exp_q.pop_front();
                    nm = nm_q.pop_front();
                    act = e[32] ? {26'd0, ja} : q;
                    if (act !== e[31:0]) begin
                        bad++;
                        $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, e[31:0], cyc);
                    end
                end
            end
            cur = ja[3:0];
            if (mon_en && cur !== prev_coil) begin
                total++;
                if (coil_q.size() == 0) begin
                    bad++;
                    $display("FAIL coil_unexpected: got %b at cycle %0d, none expected", cur, cyc);
                end else begin
                    ce = coil_q.pop_front();
                    if (ce[3:0] !== cur || int'(ce[35:4]) != cyc) begin
                        bad++;
                        $display("FAIL coil_step: got %b at cycle %0d want %b at cycle %0d",
                                 cur, cyc, ce[3:0], int'(ce[35:4]));
                    end
                end
            end
            prev_coil = cur;
        end
    end

    initial begin
        reset   = 1'b0;
        wren    = 1'b0;
        address = '0;
        data    = '0;
        tick();
        chk(K_JA, A_STAT, 32'h0, "rst_ja_init");
        reset = 1'b1;
        mon_en = 1'b1;
        chk(K_Q, A_CTRL, 32'h0, "rst_ctrl");
        chk(K_Q, A_PER,  32'h0, "rst_period");
        chk(K_Q, A_CNT,  32'h0, "rst_count");
        chk(K_Q, A_STAT, 32'h0, "rst_status");

        // half-step reverse with wrap: 0 -> 7, 6, 5 every 2 cycles
        expect_coil(4'b0001, cyc + 1);
        wr(A_CTRL, 32'h5);
        chk(K_JA, A_STAT, 32'h01, "hold_idx0");
        wr(A_PER, 32'd2);
        wr(A_CNT, 32'd3);
        s = cyc;
        expect_coil(4'b1001, s + 2);
        expect_coil(4'b1000, s + 4);
        expect_coil(4'b1100, s + 6);
        idle(8);
        chk(K_Q, A_STAT, 32'h52, "half_rev_status");
        chk(K_Q, A_CNT,  32'h0,  "half_rev_remaining");

        // half-step forward 5 -> 1, one step per cycle; done cleared on start
        wr(A_CTRL, 32'h7);
        wr(A_PER, 32'd1);
        wr(A_CNT, 32'd4);
        s = cyc;
        expect_coil(4'b1000, s + 1);
        expect_coil(4'b1001, s + 2);
        expect_coil(4'b0001, s + 3);
        expect_coil(4'b0011, s + 4);
        chk(K_Q, A_STAT, 32'h51, "start_busy_done_clr");
        idle(6);
        chk(K_Q, A_STAT, 32'h12, "half_fwd_status");
        wr(A_STAT, 32'h2);
        chk(K_Q, A_STAT, 32'h10, "done_w1c");

        // full-step forward from index 1, PERIOD=4
        wr(A_CTRL, 32'h3);
        wr(A_PER, 32'd4);
        chk(K_JA, A_STAT, 32'h03, "full_fwd_hold");
        wr(A_CNT, 32'd3);
        s = cyc;
        expect_coil(4'b0110, s + 4);
        expect_coil(4'b1100, s + 8);
        expect_coil(4'b1001, s + 12);
        idle(12);
        chk(K_JA, A_STAT, 32'h19, "full_fwd_last_step");
        chk(K_JA, A_STAT, 32'h29, "full_fwd_done");
        chk(K_Q,  A_STAT, 32'h72, "full_fwd_status");

        // PERIOD=0 behaves as 1: five consecutive steps 7 -> 4
        wr(A_CTRL, 32'h7);
        wr(A_PER, 32'd0);
        wr(A_CNT, 32'd5);
        s = cyc;
        expect_coil(4'b0001, s + 1);
        expect_coil(4'b0011, s + 2);
        expect_coil(4'b0010, s + 3);
        expect_coil(4'b0110, s + 4);
        expect_coil(4'b0100, s + 5);
        idle(1);
        for (int i = 4; i >= 0; i--) chk(K_Q, A_CNT, 32'(i), "p0_remaining");

        // abort after 4 full steps; COUNT write mid-run ignored
        wr(A_CTRL, 32'h3);
        wr(A_PER, 32'd3);
        wr(A_CNT, 32'd10);
        s = cyc;
        expect_coil(4'b1000, s + 3);
        expect_coil(4'b0001, s + 6);
        expect_coil(4'b0010, s + 9);
        expect_coil(4'b0100, s + 12);
        wr(A_CNT, 32'd1);
        idle(10);
        chk(K_Q, A_CNT, 32'd7, "run_count_ignored");
        wr(A_CTRL, 32'hB);
        chk(K_Q,  A_STAT, 32'h40, "abort_status");
        chk(K_Q,  A_CNT,  32'h0,  "abort_remaining");
        chk(K_JA, A_STAT, 32'h04, "abort_hold");
        chk(K_Q,  A_CTRL, 32'h3,  "abort_reads_0");
        idle(4);

        // EN=0 write on the very cycle a step falls due: abort wins
        wr(A_CNT, 32'd2);
        s = cyc;
        idle(2);
        expect_coil(4'b0000, s + 3);
        wr(A_CTRL, 32'h2);
        chk(K_Q, A_STAT, 32'h40, "abort_vs_step");
        chk(K_Q, A_CNT,  32'h0,  "abort_vs_step_rem");

        // ignored starts and undecoded addresses
        wr(A_CNT, 32'd5);
        chk(K_Q, A_STAT, 32'h40, "start_en0_ignored");
        expect_coil(4'b0100, cyc + 1);
        wr(A_CTRL, 32'h1);
        wr(A_CNT, 32'd0);
        chk(K_Q, A_STAT, 32'h40, "start_zero_ignored");
        wr(BASE + 12'd4, 32'hFFFF_FFFF);
        chk(K_Q, BASE + 12'd4, 32'h0, "undecoded_above");
        chk(K_Q, BASE - 12'd1, 32'h0, "undecoded_below");
        chk(K_Q, A_CTRL, 32'h1, "undecoded_no_ctrl");
        chk(K_Q, A_PER,  32'd3, "undecoded_no_period");

        // asynchronous reset mid-run
        wr(A_CNT, 32'd8);
        s = cyc;
        expect_coil(4'b0010, s + 3);
        idle(4);
        mon_en = 1'b0;
        reset  = 1'b0;
        chk(K_JA, A_STAT, 32'h0, "rst_mid_ja");
        chk(K_Q,  A_STAT, 32'h0, "rst_mid_status");
        reset  = 1'b1;
        mon_en = 1'b1;
        chk(K_Q, A_CTRL, 32'h0, "rst_mid_ctrl");
        chk(K_Q, A_CNT,  32'h0, "rst_mid_count");
        idle(3);

        total++;
        if (coil_q.size() != 0) begin
            bad++;
            $display("FAIL coil_missing: got %0d pending steps want 0", coil_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stepper_ctrl.md
Name: stepper_ctrl

Overview:
- Memory-mapped stepper-motor sequencer on the processor's data-memory bus. Decodes 4 word registers above the RAM window.
- Firmware programs direction, step mode, step period and step count. The block then drives the coil phase sequence autonomously on the 6-bit JA header.
- The processor only polls status; it never bit-bangs the coils.

Parameters:
- BASE_ADDR, 12'hFF0, word address of register 0; registers occupy BASE_ADDR..BASE_ADDR+3.
- PW, 24, width of PERIOD register and period counter (clock cycles per step).
- CW, 16, width of COUNT/remaining-step counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wren  in  1  dmem write enable from processor.
- address  in  12  dmem word address.
- data  in  32  write data.
- q  out  32  combinational read data; 0 when address is outside BASE_ADDR..+3.
- ja  out  6  [3:0] coil A+,B+,A-,B-; [4] busy; [5] done.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0 CTRL: b0 EN, b1 DIR (1 = index+), b2 HALF (1 = half-step), b3 ABORT (write-only, reads 0).
  - 1 PERIOD: [PW-1:0]. Value 0 behaves as 1.
  - 2 COUNT: a write starts a move. A read returns remaining steps.
  - 3 STATUS: b0 busy, b1 done (sticky, write-1-to-clear), b[6:4] phase index. Other bits read 0.
- Reset (async, active-low): CTRL=0, PERIOD=0, remaining=0, phase index=0, period counter=0, state IDLE, done=0.
  - ja=0 immediately on assertion, not at the next edge.
- Phase table, index 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
  - Index arithmetic is mod 8 and wraps both directions.
  - HALF=1: step is ±1. HALF=0: step is ±2, so index parity is preserved (even = wave drive, odd = two-phase).
- Coils: EN=0 → ja[3:0]=0000. EN=1 → ja[3:0]=table[index], in IDLE as well (holding torque).
- FSM states:
  - IDLE: a COUNT write with EN=1 and data[CW-1:0]≠0 → RUN at the next edge. That edge also does: remaining=data, period counter=max(PERIOD,1)-1, done cleared.
    - A COUNT write of 0, or a COUNT write with EN=0: ignored, no state change.
  - RUN: the period counter decrements each cycle. When it is 0 and remaining≠0, at the next edge:
    - index advances one step per DIR/HALF.
    - remaining decrements.
    - counter reloads max(PERIOD,1)-1.
    - If remaining becomes 0 → DONE.
  - DONE: one cycle; sets done=1, then → IDLE.
- Timing: the first coil change occurs max(PERIOD,1) cycles after the start edge. Later steps follow every max(PERIOD,1) cycles. busy = (state≠IDLE), registered.
- Writes while RUN:
  - COUNT write: ignored.
  - PERIOD write: takes effect at the next reload.
  - DIR/HALF write: takes effect on the next step.
  - CTRL write with ABORT=1 or EN=0: → IDLE at the next edge. remaining=0, done not set, index holds. If EN=0, coils de-energise.
- Simultaneous events:
  - A step-due cycle coinciding with an abort write: the abort wins and no step is taken.
  - A STATUS done-clear write in the same cycle DONE sets done: the set wins.
- Writes to non-decoded addresses have no effect. Reads are side-effect free.

Test Plan:
- Reset then idle: assert reset low mid-run → ja=0 and q(STATUS)=0 within the same cycle; after release, q(CTRL)=0.
- Full-step forward: CTRL=0x3, PERIOD=4, index 1, COUNT=3.
  - ja[3:0] sequence 0011 → 0110 @+4 → 1100 @+8 → 1001 @+12 cycles.
  - busy cleared and done=1 one cycle later.
- Half-step reverse with wrap: index 0, CTRL=0x5 (EN, HALF, DIR=0), PERIOD=2, COUNT=3 → index 7, 6, 5 (1001, 1000, 1100) every 2 cycles; STATUS[6:4]=5.
- PERIOD=0 edge: CTRL=0x7, PERIOD=0, COUNT=5 → a step every cycle, 5 coil changes, remaining reads 4, 3, 2, 1, 0.
- Abort mid-move: COUNT=10, PERIOD=3, write CTRL ABORT after 4 steps → busy falls the next cycle, done stays 0, remaining reads 0, coils hold the step-4 phase; a COUNT write during the run is ignored.
- Ignored starts: COUNT write with EN=0, and COUNT=0 with EN=1 → busy stays 0; address BASE_ADDR+4 write has no effect and reads 0.
